// File: rtl/hazard_stall_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hazard_stall_controller                                       |
// | Desc     : Pipeline stall/flush/bubble sequencer with saturating counters|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module hazard_stall_controller #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic [4:0]       rd_EX,
  input  logic             MemRead_EX,
  input  logic             muldiv_EX,
  input  logic             branch_taken_EX,
  input  logic             mem_busy,
  input  logic             perf_clr,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             stall_EX,
  output logic             stall_MEM,
  output logic             flush_ID,
  output logic             bubble_EX,
  output logic             bubble_MEM,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int                 c_MD_W    = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [c_MD_W-1:0]  c_MD_INIT = c_MD_W'(MULDIV_LAT - 2);
  localparam logic [c_MD_W-1:0]  c_MD_ONE  = c_MD_W'(1);
  localparam logic [CNT_W-1:0]   c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0]   c_CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_MD_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]  r_stall_cycles, r_flush_count;

  logic w_load_use;
  logic w_stall_if, w_stall_id, w_stall_ex, w_stall_mem;
  logic w_flush_id, w_bubble_ex, w_bubble_mem;

  assign w_load_use = MemRead_EX && (rd_EX != 5'd0) &&
                      ((use_rs1_ID && (rd_EX == rs1_ID)) ||
                       (use_rs2_ID && (rd_EX == rs2_ID)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_stall_if   = 1'b0;
    w_stall_id   = 1'b0;
    w_stall_ex   = 1'b0;
    w_stall_mem  = 1'b0;
    w_flush_id   = 1'b0;
    w_bubble_ex  = 1'b0;
    w_bubble_mem = 1'b0;
    if (mem_busy) begin
      // Memory wait freezes the whole pipe; a running mul/div keeps counting.
      w_stall_if  = 1'b1;
      w_stall_id  = 1'b1;
      w_stall_ex  = 1'b1;
      w_stall_mem = 1'b1;
      if ((r_state == ST_MD_BUSY) && (r_cnt != '0)) begin
        w_cnt_nxt = r_cnt - c_MD_ONE;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          if (muldiv_EX) begin
            w_stall_if   = 1'b1;
            w_stall_id   = 1'b1;
            w_stall_ex   = 1'b1;
            w_bubble_mem = 1'b1;
            w_cnt_nxt    = c_MD_INIT;
            w_state_nxt  = ST_MD_BUSY;
          end else if (branch_taken_EX) begin
            w_flush_id  = 1'b1;
            w_bubble_ex = 1'b1;
          end else if (w_load_use) begin
            w_stall_if  = 1'b1;
            w_stall_id  = 1'b1;
            w_bubble_ex = 1'b1;
          end
        end
        ST_MD_BUSY: begin
          if (r_cnt != '0) begin
            w_stall_if   = 1'b1;
            w_stall_id   = 1'b1;
            w_stall_ex   = 1'b1;
            w_bubble_mem = 1'b1;
            w_cnt_nxt    = r_cnt - c_MD_ONE;
          end else begin
            // Release cycle: the same op is still in EX, so its inputs are ignored.
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign stall_IF   = rst_n & w_stall_if;
  assign stall_ID   = rst_n & w_stall_id;
  assign stall_EX   = rst_n & w_stall_ex;
  assign stall_MEM  = rst_n & w_stall_mem;
  assign flush_ID   = rst_n & w_flush_id;
  assign bubble_EX  = rst_n & w_bubble_ex;
  assign bubble_MEM = rst_n & w_bubble_mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else if (perf_clr) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (stall_IF && (r_stall_cycles != c_CNT_MAX)) begin
        r_stall_cycles <= r_stall_cycles + c_CNT_ONE;
      end
      if (flush_ID && (r_flush_count != c_CNT_MAX)) begin
        r_flush_count <= r_flush_count + c_CNT_ONE;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_hazard_stall_controller                                    |
// | Desc     : Vector table, corner sequences and random run vs. a model     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_hazard_stall_controller;

  localparam int MULDIV_LAT = 4;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       rs1_ID, rs2_ID, rd_EX;
  logic             use_rs1_ID, use_rs2_ID, MemRead_EX, muldiv_EX;
  logic             branch_taken_EX, mem_busy, perf_clr;
  logic             stall_IF, stall_ID, stall_EX, stall_MEM;
  logic             flush_ID, bubble_EX, bubble_MEM;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [6:0]       w_ctl;

  always #5 clk = ~clk;

  hazard_stall_controller #(.MULDIV_LAT(MULDIV_LAT), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
    .rd_EX(rd_EX), .MemRead_EX(MemRead_EX), .muldiv_EX(muldiv_EX),
    .branch_taken_EX(branch_taken_EX), .mem_busy(mem_busy), .perf_clr(perf_clr),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX), .stall_MEM(stall_MEM),
    .flush_ID(flush_ID), .bubble_EX(bubble_EX), .bubble_MEM(bubble_MEM),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // {stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, bubble_EX, bubble_MEM}
  assign w_ctl = {stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, bubble_EX, bubble_MEM};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic md, input logic mb, input logic br, input logic mr,
                       input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic clr);
    muldiv_EX = md; mem_busy = mb; branch_taken_EX = br; MemRead_EX = mr;
    rd_EX = rd; rs1_ID = r1; rs2_ID = r2; use_rs1_ID = u1; use_rs2_ID = u2; perf_clr = clr;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    string      name;
    logic       md, mb, br, mr, u1, u2;
    logic [4:0] rd, r1, r2;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[9];

  // Reference model: an op in flight, how many more stalled cycles it owes.
  bit m_md_active;
  int m_md_left;
  int m_sc, m_fc;

  task automatic model_step(output logic [6:0] exp);
    bit lu;
    lu  = MemRead_EX && rd_EX != 0 &&
          ((use_rs1_ID && rd_EX == rs1_ID) || (use_rs2_ID && rd_EX == rs2_ID));
    exp = 7'b0;
    if (mem_busy) begin
      exp = 7'b1111000;
      if (m_md_active && m_md_left > 0) m_md_left--;
    end else if (m_md_active) begin
      if (m_md_left > 0) begin
        exp = 7'b1110001;
        m_md_left--;
      end else begin
        m_md_active = 0;
      end
    end else if (muldiv_EX) begin
      exp = 7'b1110001;
      m_md_active = 1;
      m_md_left   = MULDIV_LAT - 2;
    end else if (branch_taken_EX) begin
      exp = 7'b0000110;
    end else if (lu) begin
      exp = 7'b1100010;
    end
    if (perf_clr) begin
      m_sc = 0;
      m_fc = 0;
    end else begin
      if (exp[6] && m_sc < CNT_MAX) m_sc++;
      if (exp[2] && m_fc < CNT_MAX) m_fc++;
    end
  endtask

  initial begin
    logic [6:0] exp;
    int         sc_before, fc_before;
    logic [6:0] md_seq [4];

    vecs[0] = '{"idle",      0,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 7'b0000000};
    vecs[1] = '{"lu_rs2",    0,0,0,1,0,1, 5'd5, 5'd0, 5'd5, 7'b1100010};
    vecs[2] = '{"lu_rs1",    0,0,0,1,1,0, 5'd7, 5'd7, 5'd0, 7'b1100010};
    vecs[3] = '{"lu_rd0",    0,0,0,1,1,1, 5'd0, 5'd0, 5'd0, 7'b0000000};
    vecs[4] = '{"lu_nouse",  0,0,0,1,1,0, 5'd5, 5'd3, 5'd5, 7'b0000000};
    vecs[5] = '{"no_load",   0,0,0,0,0,1, 5'd5, 5'd0, 5'd5, 7'b0000000};
    vecs[6] = '{"redir_lu",  0,0,1,1,0,1, 5'd5, 5'd0, 5'd5, 7'b0000110};
    vecs[7] = '{"membusy",   1,1,1,1,0,1, 5'd5, 5'd0, 5'd5, 7'b1111000};
    vecs[8] = '{"muldiv",    1,0,1,1,0,1, 5'd5, 5'd0, 5'd5, 7'b1110001};

    // Reset forces every control low even with hazards present.
    rst_n = 1'b0;
    drive(1, 1, 1, 1, 5'd5, 5'd5, 5'd5, 1, 1, 0);
    #1;
    check("reset_ctl", 32'(w_ctl), 32'h0);
    check("reset_sc", 32'(stall_cycles), 32'h0);
    check("reset_fc", 32'(flush_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_reset();
      drive(vecs[i].md, vecs[i].mb, vecs[i].br, vecs[i].mr, vecs[i].rd,
            vecs[i].r1, vecs[i].r2, vecs[i].u1, vecs[i].u2, 1'b0);
      #1;
      check(vecs[i].name, 32'(w_ctl), 32'(vecs[i].exp));
    end

    // Load-use stalls once, then the bubbled EX clears it.
    do_reset();
    drive(0, 0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0);
    #1 check("lu_cycle0", 32'(w_ctl), 32'b1100010);
    @(negedge clk); idle();
    #1 check("lu_cycle1", 32'(w_ctl), 32'h0);
    check("lu_sc", 32'(stall_cycles), 32'd1);

    // Mul/div held for MULDIV_LAT cycles.
    md_seq[0] = 7'b1110001; md_seq[1] = 7'b1110001; md_seq[2] = 7'b1110001; md_seq[3] = 7'b0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      #1 check($sformatf("md_cyc%0d", c), 32'(w_ctl), 32'(md_seq[c]));
    end
    @(negedge clk); idle();
    #1 check("md_idle", 32'(w_ctl), 32'h0);
    check("md_sc", 32'(stall_cycles), 32'd3);
    check("md_fc", 32'(flush_count), 32'd0);

    // mem_busy while MD_BUSY with cnt=1, then release.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(1, (c == 2 || c == 3), 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      #1;
      if (c < 2)       check($sformatf("mb_md%0d", c), 32'(w_ctl), 32'b1110001);
      else if (c < 4)  check($sformatf("mb_md%0d", c), 32'(w_ctl), 32'b1111000);
      else             check("mb_release", 32'(w_ctl), 32'h0);
    end
    @(negedge clk); idle();
    #1 check("mb_sc", 32'(stall_cycles), 32'd4);

    // Redirect beats load-use and counts a flush.
    do_reset();
    drive(0, 0, 1, 1, 5'd9, 5'd9, 5'd0, 1, 0, 0);
    #1 check("redir_ctl", 32'(w_ctl), 32'b0000110);
    @(negedge clk); idle();
    #1 check("redir_fc", 32'(flush_count), 32'd1);
    check("redir_sc", 32'(stall_cycles), 32'd0);

    // Saturation and clear-over-increment.
    do_reset();
    for (int c = 0; c < CNT_MAX + 5; c++) begin
      @(negedge clk);
      drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    end
    @(negedge clk); idle();
    #1 check("sat_hold", 32'(stall_cycles), 32'(CNT_MAX));
    @(negedge clk);
    drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    #1 check("clr_stall_ctl", 32'(w_ctl), 32'b1111000);
    @(negedge clk); idle();
    #1 check("clr_priority", 32'(stall_cycles), 32'd0);

    // Reset in the middle of a mul/div, then a full restart.
    do_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_ctl", 32'(w_ctl), 32'h0);
    check("rst_mid_sc", 32'(stall_cycles), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      #1 check($sformatf("rst_restart%0d", c), 32'(w_ctl), 32'(md_seq[c]));
    end

    // Random traffic against the reference model.
    do_reset();
    m_md_active = 0; m_md_left = 0; m_sc = 0; m_fc = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
      #1;
      sc_before = m_sc;
      fc_before = m_fc;
      model_step(exp);
      check("rand_ctl", 32'(w_ctl), 32'(exp));
      check("rand_sc", 32'(stall_cycles), 32'(sc_before));
      check("rand_fc", 32'(flush_count), 32'(fc_before));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
